// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM between an instruction-fetch port and a load/store port.
//   Ports:
//     clk, rst (asynchronous, active-low)
//     if_req_i, if_addr_i                     -> if_data_o, if_ack_o
//     mem_req_i, mem_we_i, mem_addr_i,
//     mem_wdata_i, mem_sel_i                  -> mem_rdata_o, mem_ack_o
//     sram_data_i                             -> sram_addr_o, sram_data_o, sram_we_o, sram_sel_o, sram_ce_o
//     stallreq_o: pipeline stall while either port has an un-acked request
//   Parameter WAIT_CYCLES (1..15): SRAM cycles per transfer.
//   Macro MEM_ARB_RR_EN: defined -> round-robin on contention; undefined -> load/store always wins.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_sel_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    input  logic [31:0] sram_data_i,
    output logic [31:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    output logic        sram_we_o,
    output logic [3:0]  sram_sel_o,
    output logic        sram_ce_o,
    output logic        stallreq_o
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_mem_q, gnt_mem_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        any_req, pick_mem, grant;
    assign any_req = if_req_i | mem_req_i;
    assign grant   = (state_q == IDLE) & any_req;
`ifdef MEM_ARB_RR_EN
    // last_mem_q: 1 when the most recent grant went to load/store
    logic last_mem_q, last_mem_d;
    assign pick_mem   = mem_req_i & ~(if_req_i & last_mem_q);
    assign last_mem_d = grant ? pick_mem : last_mem_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_mem_q <= 1'b0;
        else      last_mem_q <= last_mem_d;
    end
`else
    assign pick_mem = mem_req_i;
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_mem_d   = gnt_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_INIT;
                    gnt_mem_d = pick_mem;
                    we_d      = pick_mem & mem_we_i;
                    addr_d    = pick_mem ? mem_addr_i : if_addr_i;
                    wdata_d   = pick_mem ? mem_wdata_i : 32'h0;
                    sel_d     = pick_mem ? mem_sel_i : 4'hF;
                end
            end
            BUSY: begin
                state_d = (cnt_q == 4'd0) ? ACK : BUSY;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    // stores complete without touching the load-data register
                    mem_rdata_d = (gnt_mem_q & ~we_q) ? sram_data_i : mem_rdata_q;
                    if_data_d   = gnt_mem_q ? if_data_q : sram_data_i;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            gnt_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            sel_q       <= 4'h0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_mem_q   <= gnt_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end
    assign sram_ce_o   = state_q == BUSY;
    assign sram_we_o   = sram_ce_o & we_q;
    assign sram_addr_o = addr_q;
    assign sram_data_o = wdata_q;
    assign sram_sel_o  = sel_q;
    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_ack_o    = (state_q == ACK) & ~gnt_mem_q;
    assign mem_ack_o   = (state_q == ACK) & gnt_mem_q;
    assign stallreq_o  = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM access cycles per transfer; legal range 1..15.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  instruction-fetch request
- if_addr_i  in  32  fetch address
- if_data_o  out  32  fetched word
- if_ack_o  out  1  one-cycle fetch completion pulse
- mem_req_i  in  1  load/store request
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  load/store address
- mem_wdata_i  in  32  store data
- mem_sel_i  in  4  byte enables
- mem_rdata_o  out  32  load data
- mem_ack_o  out  1  one-cycle load/store completion pulse
- sram_data_i  in  32  SRAM read data
- sram_addr_o  out  32  SRAM address
- sram_data_o  out  32  SRAM write data
- sram_we_o  out  1  SRAM write enable, active-high
- sram_sel_o  out  4  SRAM byte enables
- sram_ce_o  out  1  SRAM chip enable, active-high
- stallreq_o  out  1  pipeline stall request

Function
REQ-003 SHALL share one SRAM between fetch port and load/store port, one transfer at a time.
REQ-004 SHALL implement FSM IDLE -> BUSY -> ACK -> IDLE; no other transitions.
REQ-005 IDLE: samples requests each edge; with any request, latches the granted port's addr/we/wdata/sel into registered SRAM outputs, loads counter with WAIT_CYCLES-1, enters BUSY.
REQ-006 BUSY: sram_ce_o=1; sram_we_o=latched we (always 0 for fetch); counter decrements each edge; on edge with counter=0, captures sram_data_i into the granted port's read-data register, pulses that port's ack, enters ACK.
REQ-007 ACK: sram_ce_o=0, sram_we_o=0; ack high exactly this one cycle; requests ignored; next edge -> IDLE.
REQ-008 Latency: request sampled at edge N -> ack high between edges N+WAIT_CYCLES and N+WAIT_CYCLES+1; back-to-back throughput one transfer per WAIT_CYCLES+2 cycles.
REQ-009 Requester SHALL hold req and operands stable until its ack; arbiter latches operands only at grant, so later changes do not affect an in-flight transfer.
REQ-010 Contention in IDLE (both req): grant per REQ-017; the loser stays pending, granted on the next IDLE sample.
REQ-011 if_data_o/mem_rdata_o SHALL hold their last captured value until the next read on the same port; store acks leave mem_rdata_o unchanged.
REQ-012 stallreq_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-013 Request deasserted while BUSY: transfer still completes, ack still pulses.

Reset
REQ-014 rst low SHALL immediately (asynchronously) force state IDLE, counter 0, and all outputs 0 (sram_ce_o=0, sram_we_o=0, both acks 0, both read-data registers 0), aborting any in-flight transfer without an ack.
REQ-015 After rst high, first grant possible at the first rising edge.
REQ-016 Round-robin last-grant register SHALL reset to "fetch".

Configuration
REQ-017 Macro MEM_ARB_RR_EN: undefined -> fixed priority, load/store always wins contention; defined -> round-robin, contention grants the port not granted last; last-grant register updates on every grant.

Verification
REQ-018 WAIT_CYCLES=2, fetch only, addr 0x80000000, sram_data_i=0x12345678 -> sram_ce_o high 2 cycles, if_ack_o pulses once 2 edges after sampling, if_data_o=0x12345678.
REQ-019 Store addr 0x80400004, wdata 0xDEADBEEF, sel 4'b0011 -> sram_we_o=1, sram_sel_o=4'b0011, sram_data_o=0xDEADBEEF for 2 cycles, one mem_ack_o, mem_rdata_o unchanged.
REQ-020 Both req asserted continuously, fixed priority -> order mem, if; 4-cycle spacing between acks; stallreq_o high until each port acked.
REQ-021 MEM_ARB_RR_EN defined, both req held for 4 transfers -> grants alternate mem, if, mem, if.
REQ-022 rst low mid-BUSY -> sram_ce_o drops before next edge, no ack; after release, held request restarts and completes normally.
REQ-023 WAIT_CYCLES=1 and 15 -> ack exactly 1 and 15 edges after grant.
